// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: opcodes, NOP encoding, ALU-op
// enum, the control bundle handed to ID/EX, and the opcode-to-control decoder.
package id_stage_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        aluop_e aluop;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[6:0])
            OPC_R: begin
                c.reg_write = 1'b1;
                c.aluop     = ALUOP_FUNCT;
            end
            OPC_I_ALU: begin
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.aluop     = ALUOP_FUNCT;
            end
            OPC_LOAD: begin
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.aluop      = ALUOP_ADD;
            end
            OPC_STORE: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
                c.aluop     = ALUOP_ADD;
            end
            OPC_BRANCH: c.aluop = ALUOP_SUB;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Only formats that actually read rs2 may create a load-use hazard on rt.
    function automatic logic uses_rt(input logic [31:0] instr);
        return (instr[6:0] == OPC_R) || (instr[6:0] == OPC_STORE) ||
               (instr[6:0] == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file, two read ports and one write port; x0 reads as zero.
// Define ID_STAGE_WB_BYPASS_EN to forward a same-cycle write to the read ports.
module reg_file
    import id_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic              wr_en;

    assign wr_en = we && (wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        if (ra == '0) return '0;
`ifdef ID_STAGE_WB_BYPASS_EN
        if (wr_en && (wa == ra)) return wd;
`endif
        return regs[ra];
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, control decode, immediate generation, load-use
// stall detection and register-file read. Optional macro: ID_STAGE_WB_BYPASS_EN.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr_in,
    input  logic        if_valid_in,
    input  logic        flush_in,
    input  logic        ex_memread_in,
    input  logic [4:0]  ex_rd_in,
    input  logic        wb_regwrite_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_data_in,
    output logic        stall_out,
    output logic        AluSrc_out,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic        MemRead_out,
    output logic        MemWrite_out,
    output logic [1:0]  Aluop_out,
    output logic [31:0] rs1Data_out,
    output logic [31:0] rs2Data_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [31:0] immediate_out
);

    logic [31:0] instr_p0;
    logic        vld_p0;
    ctrl_t       dec_ctrl;
    ctrl_t       ctrl;

    // IF/ID boundary: flush beats stall, reset beats both.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_p0 <= NOP_INSTR;
            vld_p0   <= 1'b0;
        end else if (flush_in) begin
            instr_p0 <= NOP_INSTR;
            vld_p0   <= 1'b0;
        end else if (!stall_out) begin
            instr_p0 <= if_instr_in;
            vld_p0   <= if_valid_in;
        end
    end

    function automatic logic signed [31:0] imm_gen(input logic [31:0] instr);
        logic signed [31:0] imm;
        case (instr[6:0])
            OPC_I_ALU, OPC_LOAD: imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:           imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:          imm = {{19{instr[31]}}, instr[31], instr[7],
                                        instr[30:25], instr[11:8], 1'b0};
            default:             imm = '0;
        endcase
        return imm;
    endfunction

    assign rs_out        = instr_p0[19:15];
    assign rt_out        = instr_p0[24:20];
    assign rd_out        = instr_p0[11:7];
    assign immediate_out = imm_gen(instr_p0);

    assign stall_out = vld_p0 && ex_memread_in && (ex_rd_in != 5'd0) &&
                       ((ex_rd_in == rs_out) ||
                        (uses_rt(instr_p0) && (ex_rd_in == rt_out)));

    assign dec_ctrl = decode_ctrl(instr_p0);
    assign ctrl     = (stall_out || !vld_p0) ? ctrl_t'('0) : dec_ctrl;

    assign AluSrc_out   = ctrl.alu_src;
    assign MemtoReg_out = ctrl.mem_to_reg;
    assign RegWrite_out = ctrl.reg_write;
    assign MemRead_out  = ctrl.mem_read;
    assign MemWrite_out = ctrl.mem_write;
    assign Aluop_out    = ctrl.aluop;

    reg_file #(.DATA_W(32), .ADDR_W(5)) u_reg_file (
        .clk (clk),
        .rst (rst),
        .ra1 (rs_out),
        .ra2 (rt_out),
        .we  (wb_regwrite_in),
        .wa  (wb_rd_in),
        .wd  (wb_data_in),
        .rd1 (rs1Data_out),
        .rd2 (rs2Data_out)
    );

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst, and the polarity and synchronicity are fixed.
REQ-002 clk  in  1  rising-edge clock for the IF/ID register and register file.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 if_instr_in  in  32  fetched instruction; if_valid_in  in  1  fetch slot holds a real instruction.
REQ-005 flush_in  in  1  squashes the IF/ID contents (taken branch from EX).
REQ-006 ex_memread_in  in  1 and ex_rd_in  in  5  MemRead and rd currently held in the ID/EX register, used for load-use detection.
REQ-007 wb_regwrite_in  in  1, wb_rd_in  in  5, wb_data_in  in  32  write-back port.
REQ-008 stall_out  out  1  holds the PC and fetch slot.
REQ-009 AluSrc_out, MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out  out  1 each  decoded controls to ID/EX.
REQ-010 Aluop_out  out  2  00 add (load/store), 01 sub (branch), 10 funct-decoded (R/I ALU).
REQ-011 rs1Data_out, rs2Data_out  out  32; rs_out, rt_out, rd_out  out  5; immediate_out  out  32.

Function
REQ-012 The IF/ID register (instr, valid) SHALL capture if_instr_in/if_valid_in on each rising edge when stall_out=0 and flush_in=0.
REQ-013 With stall_out=1 and flush_in=0, IF/ID SHALL hold its value.
REQ-014 flush_in=1 SHALL load valid=0 and instr=NOP (0x00000013) on the edge, overriding a stall.
REQ-015 All outputs SHALL be combinational from IF/ID and the register file; decode latency is one cycle from fetch capture.
REQ-016 Decoding SHALL be: R (0110011) RegWrite, Aluop=10; I-ALU (0010011) AluSrc, RegWrite, Aluop=10; load (0000011) AluSrc, MemRead, MemtoReg, RegWrite, Aluop=00; store (0100011) AluSrc, MemWrite, Aluop=00; branch (1100011) Aluop=01; any other opcode all controls 0.
REQ-017 The immediate SHALL be sign-extended: I from [31:20]; S from {[31:25],[11:7]}; B from {[31],[7],[30:25],[11:8],0}; other formats 0.
REQ-018 rs_out=instr[19:15], rt_out=instr[24:20], rd_out=instr[11:7], regardless of controls.
REQ-019 stall_out SHALL be 1 iff valid, ex_memread_in=1, ex_rd_in≠0, and ex_rd_in equals rs_out, or equals rt_out for R, store, or branch.
REQ-020 While stall_out=1 or valid=0, all five 1-bit controls and Aluop_out SHALL be 0 (bubble); data, index, and immediate outputs stay unconstrained.
REQ-021 The register file SHALL be 32x32; reads of x0 return 0; writes with wb_regwrite_in=1 and wb_rd_in≠0 commit on the rising edge, independent of stall/flush.

Reset
REQ-022 rst=1 SHALL set IF/ID valid=0, instr=NOP, and all 32 registers to 0 on the edge.
REQ-023 After reset, all control outputs and stall_out SHALL be 0; rs1Data_out=rs2Data_out=0.
REQ-024 Reset asserted during a stall SHALL clear the stall on the same edge; a write-back coincident with reset SHALL be dropped.

Configuration
REQ-025 Macro ID_STAGE_WB_BYPASS_EN defined: a read whose index equals a same-cycle valid write (wb_regwrite_in=1, wb_rd_in≠0) SHALL return wb_data_in.
REQ-026 Macro undefined: reads SHALL return the stored value only; the new value is visible the cycle after the write edge.

Structure
REQ-027 Package id_stage_pkg SHALL hold opcode constants, NOP_INSTR, the Aluop enum, and a ctrl_t struct of the six control fields.
REQ-028 The register file SHALL be a separate sub-module reg_file (2 read ports, 1 write port, bypass macro inside).

Verification
REQ-029 Reset, then if_instr_in=0x00A00093 (addi x1,x0,10): next cycle AluSrc=1, RegWrite=1, Aluop=10, immediate_out=10, rd_out=1.
REQ-030 Write x5=0xDEADBEEF via WB port, then decode add x6,x5,x5: rs1Data=rs2Data=0xDEADBEEF; with bypass, same-cycle write and read also return 0xDEADBEEF.
REQ-031 ex_memread_in=1, ex_rd_in=5, IF/ID holds add x6,x5,x0: stall_out=1, controls 0, IF/ID held; next cycle with ex_memread_in=0 the add decodes normally.
REQ-032 Stall active and flush_in=1: next cycle valid=0, stall_out=0, controls 0.
REQ-033 sw x2,-4(x3) (0xFE212E23): MemWrite=1, AluSrc=1, immediate_out=0xFFFFFFFC; wb_rd_in=0 with wb_data_in=7 leaves x0 reading 0.
